// File: rtl/ddr_arb_pkg.sv
// Shared types for the MIG app-port arbiter.
//   arb_state_t : arbiter FSM states
//   APP_CMD_*   : MIG app_cmd encodings
//   owner_t     : which requester holds (or last held) the app port
//   pick_owner  : round-robin winner among the pending requesters
package ddr_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_H_WR,
    ST_H_RD_CMD,
    ST_H_RD_WAIT,
    ST_S_RD_CMD,
    ST_S_RD_WAIT
  } arb_state_t;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

  typedef enum logic {
    OWN_H = 1'b0,
    OWN_S = 1'b1
  } owner_t;

  // On a tie the requester that did not win last time gets the port.
  function automatic owner_t pick_owner(input logic h, input logic s, input owner_t last);
    if (h && s) return (last == OWN_H) ? OWN_S : OWN_H;
    else if (h) return OWN_H;
    else        return OWN_S;
  endfunction

endpackage

// File: rtl/ddr_line_gather.sv
// Collects LINE_BEATS read beats into one line for the search requester.
//   clk, rst      : ui_clk, async active-low reset
//   collect       : high while the search requester owns the app port
//   beat_valid    : app_rd_data_valid
//   beat_data     : app_rd_data
//   line_done     : combinational, the final beat of the line is being captured now
//   line_data     : assembled line, beat i in lane i; held until the next line completes
//   line_valid    : 1-cycle pulse the cycle after the final beat
module ddr_line_gather #(
  parameter int DATA_WIDTH = 64,
  parameter int LINE_BEATS = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             collect,
  input  logic                             beat_valid,
  input  logic [DATA_WIDTH-1:0]            beat_data,
  output logic                             line_done,
  output logic [LINE_BEATS*DATA_WIDTH-1:0] line_data,
  output logic                             line_valid
);

  localparam int CNT_W = $clog2(LINE_BEATS);

  logic [CNT_W-1:0]                    beat_cnt;
  // Only the first LINE_BEATS-1 lanes need staging; the last beat goes
  // straight into line_data so the published line changes in one step.
  logic [(LINE_BEATS-1)*DATA_WIDTH-1:0] acc;

  assign line_done = collect && beat_valid && (beat_cnt == CNT_W'(LINE_BEATS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt   <= '0;
      acc        <= '0;
      line_data  <= '0;
      line_valid <= 1'b0;
    end else begin
      line_valid <= 1'b0;
      if (!collect) begin
        beat_cnt <= '0;
      end else if (beat_valid) begin
        if (line_done) begin
          line_data  <= {beat_data, acc};
          line_valid <= 1'b1;
          beat_cnt   <= '0;
        end else begin
          for (int i = 0; i < LINE_BEATS - 1; i++) begin
            if (beat_cnt == CNT_W'(i)) acc[i*DATA_WIDTH +: DATA_WIDTH] <= beat_data;
          end
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ddr_app_arbiter.sv
// Round-robin, transaction-granular arbiter sharing the MIG app port between
// the host bridge (H: single 64-bit read/write) and the search interface
// (S: line reads of LINE_BEATS consecutive read commands).
//   clk, rst                 : MIG ui_clk, async active-low reset
//   init_calib_complete      : no new grant while low
//   h_req/h_we/h_addr/h_wdata: host request, held until h_ack
//   h_ack, h_rdata, h_rvalid : host accept pulse and read return
//   s_arvalid/s_araddr       : search line request, held until s_arready
//   s_arready                : grant pulse (combinational, in the grant cycle)
//   s_rdata, s_rvalid        : assembled line and its completion pulse
//   app_*                    : MIG application interface
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | port free; grants when calibrated and a request is pending
// ST_H_WR      | host write: command and write data handshakes in flight
// ST_H_RD_CMD  | host read command waiting for app_rdy
// ST_H_RD_WAIT | host read command accepted, waiting for the data beat
// ST_S_RD_CMD  | issuing the line read commands back to back
// ST_S_RD_WAIT | all line commands issued, collecting remaining beats
module ddr_app_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 64,
  parameter int LINE_BEATS = 8,
  parameter int ADDR_STEP  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             init_calib_complete,
  input  logic                             h_req,
  input  logic                             h_we,
  input  logic [ADDR_WIDTH-1:0]            h_addr,
  input  logic [DATA_WIDTH-1:0]            h_wdata,
  output logic                             h_ack,
  output logic [DATA_WIDTH-1:0]            h_rdata,
  output logic                             h_rvalid,
  input  logic                             s_arvalid,
  input  logic [ADDR_WIDTH-1:0]            s_araddr,
  output logic                             s_arready,
  output logic [LINE_BEATS*DATA_WIDTH-1:0] s_rdata,
  output logic                             s_rvalid,
  output logic [ADDR_WIDTH-1:0]            app_addr,
  output logic [2:0]                       app_cmd,
  output logic                             app_en,
  input  logic                             app_rdy,
  output logic [DATA_WIDTH-1:0]            app_wdf_data,
  output logic                             app_wdf_wren,
  output logic                             app_wdf_end,
  input  logic                             app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]            app_rd_data,
  input  logic                             app_rd_data_valid
);

  localparam int CNT_W = $clog2(LINE_BEATS);

  arb_state_t      state;
  owner_t          last_grant;
  owner_t          win;
  logic [CNT_W-1:0] cmd_cnt;
  logic            h_cand;
  logic            grant_ok;
  logic            collect;
  logic            line_done;
  logic [ADDR_WIDTH-1:0] s_base;

  // h_ack is registered, so it is seen by the host while we are already back
  // in IDLE with h_req still high; masking stops a duplicate grant.
  assign h_cand   = h_req && !h_ack;
  assign grant_ok = init_calib_complete && (h_cand || s_arvalid);
  assign win      = pick_owner(h_cand, s_arvalid, last_grant);
  assign s_base   = s_araddr & ~ADDR_WIDTH'(ADDR_STEP - 1);

  // Gated with rst so the port stays quiet while reset is held.
  assign s_arready = rst && (state == ST_IDLE) && grant_ok && (win == OWN_S);

  assign collect = (state == ST_S_RD_CMD) || (state == ST_S_RD_WAIT);

  ddr_line_gather #(
    .DATA_WIDTH(DATA_WIDTH),
    .LINE_BEATS(LINE_BEATS)
  ) u_gather (
    .clk       (clk),
    .rst       (rst),
    .collect   (collect),
    .beat_valid(app_rd_data_valid),
    .beat_data (app_rd_data),
    .line_done (line_done),
    .line_data (s_rdata),
    .line_valid(s_rvalid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      last_grant   <= OWN_S;
      cmd_cnt      <= '0;
      app_addr     <= '0;
      app_cmd      <= '0;
      app_en       <= 1'b0;
      app_wdf_data <= '0;
      app_wdf_wren <= 1'b0;
      app_wdf_end  <= 1'b0;
      h_ack        <= 1'b0;
      h_rdata      <= '0;
      h_rvalid     <= 1'b0;
    end else begin
      h_ack    <= 1'b0;
      h_rvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_ok) begin
            last_grant <= win;
            app_en     <= 1'b1;
            if (win == OWN_H) begin
              app_addr <= h_addr;
              if (h_we) begin
                app_cmd      <= APP_CMD_WR;
                app_wdf_data <= h_wdata;
                app_wdf_wren <= 1'b1;
                app_wdf_end  <= 1'b1;
                state        <= ST_H_WR;
              end else begin
                app_cmd <= APP_CMD_RD;
                state   <= ST_H_RD_CMD;
              end
            end else begin
              app_addr <= s_base;
              app_cmd  <= APP_CMD_RD;
              cmd_cnt  <= '0;
              state    <= ST_S_RD_CMD;
            end
          end
        end
        ST_H_WR: begin
          // Command and data channels finish independently, in either order.
          if (app_rdy) app_en <= 1'b0;
          if (app_wdf_rdy) begin
            app_wdf_wren <= 1'b0;
            app_wdf_end  <= 1'b0;
          end
          if ((!app_en || app_rdy) && (!app_wdf_wren || app_wdf_rdy)) begin
            h_ack <= 1'b1;
            state <= ST_IDLE;
          end
        end
        ST_H_RD_CMD: begin
          if (app_rdy) begin
            app_en <= 1'b0;
            h_ack  <= 1'b1;
            state  <= ST_H_RD_WAIT;
          end
        end
        ST_H_RD_WAIT: begin
          if (app_rd_data_valid) begin
            h_rdata  <= app_rd_data;
            h_rvalid <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        ST_S_RD_CMD: begin
          if (app_rdy) begin
            if (cmd_cnt == CNT_W'(LINE_BEATS - 1)) begin
              app_en <= 1'b0;
              state  <= ST_S_RD_WAIT;
            end else begin
              cmd_cnt  <= cmd_cnt + 1'b1;
              app_addr <= app_addr + ADDR_WIDTH'(ADDR_STEP);
            end
          end
        end
        ST_S_RD_WAIT: begin
          if (line_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_app_arbiter.sv
module tb_ddr_app_arbiter;

  logic          clk;
  logic          rst;
  logic          init_calib_complete;
  logic          h_req;
  logic          h_we;
  logic [27:0]   h_addr;
  logic [63:0]   h_wdata;
  logic          h_ack;
  logic [63:0]   h_rdata;
  logic          h_rvalid;
  logic          s_arvalid;
  logic [27:0]   s_araddr;
  logic          s_arready;
  logic [511:0]  s_rdata;
  logic          s_rvalid;
  logic [27:0]   app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic          app_rdy;
  logic [63:0]   app_wdf_data;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic          app_wdf_rdy;
  logic [63:0]   app_rd_data;
  logic          app_rd_data_valid;

  int n_pass  = 0;
  int n_total = 0;

  ddr_app_arbiter dut (
    .clk                (clk),
    .rst                (rst),
    .init_calib_complete(init_calib_complete),
    .h_req              (h_req),
    .h_we               (h_we),
    .h_addr             (h_addr),
    .h_wdata            (h_wdata),
    .h_ack              (h_ack),
    .h_rdata            (h_rdata),
    .h_rvalid           (h_rvalid),
    .s_arvalid          (s_arvalid),
    .s_araddr           (s_araddr),
    .s_arready          (s_arready),
    .s_rdata            (s_rdata),
    .s_rvalid           (s_rvalid),
    .app_addr           (app_addr),
    .app_cmd            (app_cmd),
    .app_en             (app_en),
    .app_rdy            (app_rdy),
    .app_wdf_data       (app_wdf_data),
    .app_wdf_wren       (app_wdf_wren),
    .app_wdf_end        (app_wdf_end),
    .app_wdf_rdy        (app_wdf_rdy),
    .app_rd_data        (app_rd_data),
    .app_rd_data_valid  (app_rd_data_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs a granted line read to completion: app_rdy either steady or toggling,
  // each accepted command answered by one beat (tag | beat index) a cycle or more later.
  task automatic run_line(input bit toggle, input logic [27:0] base, input logic [63:0] tag,
                          output int ncmd, output int npulse);
    int  ret;
    bit  hs;
    bit  rv;
    ncmd   = 0;
    ret    = 0;
    npulse = 0;
    for (int c = 0; c < 80 && npulse == 0; c++) begin
      app_rdy = toggle ? (c % 2 == 1) : 1'b1;
      #1;
      hs = app_en && app_rdy;
      if (hs) chk("s_cmd_addr", app_addr, base + 28'(8 * ncmd));
      rv = (ret < ncmd);
      app_rd_data_valid = rv;
      app_rd_data       = tag | 64'(ret);
      tick();
      if (hs) ncmd++;
      if (rv) ret++;
      if (s_rvalid) npulse++;
    end
    app_rd_data_valid = 1'b0;
    app_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (s_rvalid) npulse++;
    end
  endtask

  logic [511:0] exp_line;
  logic [27:0]  exp_addr [8];
  int           ncmd;
  int           npulse;

  initial begin
    rst = 1'b0;
    init_calib_complete = 1'b1;
    h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
    s_arvalid = 0; s_araddr = '0;
    app_rdy = 1; app_wdf_rdy = 1; app_rd_data = '0; app_rd_data_valid = 0;
    #23;
    chk("rst_app_en",   app_en, 0);
    chk("rst_wren",     app_wdf_wren, 0);
    chk("rst_app_addr", app_addr, 0);
    chk("rst_h_ack",    h_ack, 0);
    chk("rst_s_rvalid", s_rvalid, 0);
    chk("rst_s_rdata",  s_rdata, 0);
    chk("rst_h_rdata",  h_rdata, 0);
    rst = 1'b1;
    tick();

    // Host write, both ready immediately
    h_req = 1; h_we = 1; h_addr = 28'h100; h_wdata = 64'hDEADBEEF_01234567;
    tick();
    chk("wr1_en",    app_en, 1);
    chk("wr1_cmd",   app_cmd, 3'b000);
    chk("wr1_addr",  app_addr, 28'h100);
    chk("wr1_wren",  app_wdf_wren, 1);
    chk("wr1_end",   app_wdf_end, 1);
    chk("wr1_wdata", app_wdf_data, 64'hDEADBEEF_01234567);
    chk("wr1_ack0",  h_ack, 0);
    tick();
    chk("wr1_en_drop",   app_en, 0);
    chk("wr1_wren_drop", app_wdf_wren, 0);
    chk("wr1_ack",       h_ack, 1);
    h_req = 0;
    tick();
    chk("wr1_ack_pulse", h_ack, 0);
    chk("wr1_no_regrant", app_en, 0);

    // Host write, app_rdy at cycle 1, app_wdf_rdy only at cycle 4
    h_req = 1; h_we = 1; h_addr = 28'h108; h_wdata = 64'h1111_2222_3333_4444;
    app_wdf_rdy = 0;
    tick();
    chk("wr2_en", app_en, 1);
    tick();
    chk("wr2_en_drop",  app_en, 0);
    chk("wr2_wren_hold", app_wdf_wren, 1);
    chk("wr2_ack_early", h_ack, 0);
    tick();
    tick();
    chk("wr2_en_not_reasserted", app_en, 0);
    chk("wr2_wren_hold3", app_wdf_wren, 1);
    chk("wr2_ack_early3", h_ack, 0);
    app_wdf_rdy = 1;
    tick();
    chk("wr2_ack",  h_ack, 1);
    chk("wr2_wren_drop", app_wdf_wren, 0);
    h_req = 0;
    tick();
    chk("wr2_ack_pulse", h_ack, 0);

    // Both request, last grant was H -> S wins; line base wraps
    h_req = 1; h_we = 0; h_addr = 28'h300;
    s_arvalid = 1; s_araddr = 28'h0FFFFFFC;
    #1;
    chk("rr_s_first_arready", s_arready, 1);
    tick();
    s_arvalid = 0;
    exp_addr[0] = 28'h0FFFFF8;
    exp_addr[0] = 28'h0FFFFFF8;
    exp_addr[1] = 28'h0000000;
    exp_addr[2] = 28'h0000008;
    exp_addr[3] = 28'h0000010;
    exp_addr[4] = 28'h0000018;
    exp_addr[5] = 28'h0000020;
    exp_addr[6] = 28'h0000028;
    exp_addr[7] = 28'h0000030;
    chk("s3_cmd", app_cmd, 3'b001);
    for (int k = 0; k < 8; k++) begin
      chk("s3_en", app_en, 1);
      chk("s3_addr", app_addr, exp_addr[k]);
      tick();
    end
    chk("s3_en_done", app_en, 0);
    for (int i = 0; i < 8; i++) begin
      app_rd_data_valid = 1;
      app_rd_data = 64'hBEEF_0000_0000_0000 | 64'(i);
      exp_line[64*i +: 64] = 64'hBEEF_0000_0000_0000 | 64'(i);
      tick();
    end
    app_rd_data_valid = 0;
    chk("s3_rvalid", s_rvalid, 1);
    chk("s3_rdata",  s_rdata, exp_line);
    chk("s3_h_ack_wait", h_ack, 0);
    tick();
    chk("s3_rvalid_pulse", s_rvalid, 0);
    chk("s3_rdata_hold",   s_rdata, exp_line);
    chk("h3_rd_en",   app_en, 1);
    chk("h3_rd_cmd",  app_cmd, 3'b001);
    chk("h3_rd_addr", app_addr, 28'h300);
    tick();
    chk("h3_ack", h_ack, 1);
    h_req = 0;
    app_rd_data_valid = 1; app_rd_data = 64'h5555_AAAA_1234_5678;
    tick();
    app_rd_data_valid = 0;
    chk("h3_rvalid", h_rvalid, 1);
    chk("h3_rdata",  h_rdata, 64'h5555_AAAA_1234_5678);
    tick();
    chk("h3_rvalid_pulse", h_rvalid, 0);

    // Line read with app_rdy toggling and beats overlapping command issue
    s_arvalid = 1; s_araddr = 28'h205;
    tick();
    s_arvalid = 0;
    chk("s4_base", app_addr, 28'h200);
    run_line(1'b1, 28'h200, 64'h0, ncmd, npulse);
    chk("s4_ncmd",   ncmd, 8);
    chk("s4_pulses", npulse, 1);
    for (int i = 0; i < 8; i++) exp_line[64*i +: 64] = 64'(i);
    chk("s4_rdata", s_rdata, exp_line);
    chk("s4_en_idle", app_en, 0);

    // After reset, simultaneous requests: H first, then S
    rst = 0; #2; rst = 1;
    tick();
    h_req = 1; h_we = 0; h_addr = 28'h40;
    s_arvalid = 1; s_araddr = 28'h80;
    #1;
    chk("rr_h_first_arready", s_arready, 0);
    tick();
    chk("rr_h_addr", app_addr, 28'h40);
    chk("rr_h_cmd",  app_cmd, 3'b001);
    chk("rr_s_wait", s_arready, 0);
    tick();
    chk("rr_h_ack", h_ack, 1);
    h_req = 0;
    app_rd_data_valid = 1; app_rd_data = 64'hCAFE;
    tick();
    app_rd_data_valid = 0;
    chk("rr_h_rvalid", h_rvalid, 1);
    chk("rr_h_rdata",  h_rdata, 64'hCAFE);
    chk("rr_s_next",   s_arready, 1);
    tick();
    s_arvalid = 0;
    chk("rr_s_addr", app_addr, 28'h80);
    run_line(1'b0, 28'h80, 64'h7700_0000_0000_0000, ncmd, npulse);
    chk("rr_s_ncmd",   ncmd, 8);
    chk("rr_s_pulses", npulse, 1);

    // Calibration gating, then reset in the middle of a line
    init_calib_complete = 0;
    h_req = 1; h_we = 1; h_addr = 28'h500; h_wdata = 64'h99;
    s_arvalid = 1; s_araddr = 28'h600;
    for (int c = 0; c < 5; c++) tick();
    chk("cal_no_en",      app_en, 0);
    chk("cal_no_arready", s_arready, 0);
    init_calib_complete = 1;
    #1;
    chk("cal_h_wins", s_arready, 0);
    tick();
    chk("cal_h_en",  app_en, 1);
    chk("cal_h_cmd", app_cmd, 3'b000);
    chk("cal_h_addr", app_addr, 28'h500);
    tick();
    chk("cal_h_ack", h_ack, 1);
    h_req = 0;
    #1;
    chk("cal_s_arready", s_arready, 1);
    tick();
    s_arvalid = 0;
    init_calib_complete = 0;
    tick(); tick(); tick();
    chk("mid_en_kept",   app_en, 1);
    chk("mid_addr",      app_addr, 28'h618);
    rst = 0;
    #1;
    chk("mid_rst_en",     app_en, 0);
    chk("mid_rst_addr",   app_addr, 0);
    chk("mid_rst_wren",   app_wdf_wren, 0);
    chk("mid_rst_rdata",  s_rdata, 0);
    chk("mid_rst_hrdata", h_rdata, 0);
    chk("mid_rst_arready", s_arready, 0);
    #1;
    rst = 1;
    init_calib_complete = 1;
    npulse = 0;
    for (int i = 0; i < 8; i++) begin
      app_rd_data_valid = 1; app_rd_data = 64'(i);
      tick();
      if (s_rvalid) npulse++;
    end
    app_rd_data_valid = 0;
    chk("mid_no_rvalid", npulse, 0);
    chk("mid_idle_en",   app_en, 0);
    chk("mid_idle_rdata", s_rdata, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
